// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) multiply-by-constant functions, word/state types
// and the MixColumns engine FSM encoding.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_fsm_t;

    // Multiply by x modulo the AES field polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // 9x = 8x ^ x
    function automatic logic [7:0] gmul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    // 11x = 8x ^ 2x ^ x
    function automatic logic [7:0] gmul11(input logic [7:0] x);
        logic [7:0] x2;
        x2 = xtime(x);
        return xtime(xtime(x2)) ^ x2 ^ x;
    endfunction

    // 13x = 8x ^ 4x ^ x
    function automatic logic [7:0] gmul13(input logic [7:0] x);
        logic [7:0] x4;
        x4 = xtime(xtime(x));
        return xtime(x4) ^ x4 ^ x;
    endfunction

    // 14x = 8x ^ 4x ^ 2x
    function automatic logic [7:0] gmul14(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x4;
        x2 = xtime(x);
        x4 = xtime(x2);
        return xtime(x4) ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/mix_columns_engine_word.sv
// One-column MixColumns / InvMixColumns, purely combinational.
// Row 0 sits in the top byte of the column word.
module mix_column_word
    import aes_pkg::*;
(
    input  aes_word_t col_in,
    input  logic      inv,
    output aes_word_t col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] f0, f1, f2, f3;
    logic [7:0] i0, i1, i2, i3;

    // Forward and inverse circulants evaluated in parallel, then selected.
    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];

        f0 = gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3;
        f1 = a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3;
        f2 = a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3);
        f3 = gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3);

        i0 = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
        i1 = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
        i2 = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
        i3 = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

        col_out = inv ? {i0, i1, i2, i3} : {f0, f1, f2, f3};
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential MixColumns / InvMixColumns engine. A state is latched on accept,
// transformed in place COLS_PER_CYCLE columns per beat, then held on the
// output handshake. DONE can drain and reload on the same edge.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    localparam int BEATS = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_fsm_t              state_q, state_d;
    aes_state_t           data_q, data_d;
    logic                 mode_q, mode_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;

    aes_word_t [3:0]                    words_q;
    aes_word_t [3:0]                    words_d;
    logic [COLS_PER_CYCLE-1:0][1:0]     col_sel;
    aes_word_t [COLS_PER_CYCLE-1:0]     col_in;
    aes_word_t [COLS_PER_CYCLE-1:0]     col_out;

    assign words_q = data_q;

    // One column transformer per lane, fed from the column slot picked by cnt.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        always_comb begin
            col_sel[g] = 2'(int'(cnt_q) * COLS_PER_CYCLE + g);
            col_in[g]  = words_q[col_sel[g]];
        end

        mix_column_word u_mcw (
            .col_in  (col_in[g]),
            .inv     (mode_q),
            .col_out (col_out[g])
        );
    end

    // Ready is a pure function of FSM state; DONE passes out_ready through.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Next-state: load, per-beat in-place column write-back, drain/reload.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        words_d     = words_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = state_in;
                    mode_d  = inv_mode;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    words_d[col_sel[g]] = col_out[g];
                end
                data_d = words_d;
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        data_d  = state_in;
                        mode_d  = inv_mode;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any in-flight state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign state_out = data_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: three instances (1, 2 and 4 columns
// per cycle) share control inputs and get independent state inputs.
module tb_mix_columns_engine;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inv_mode;
    logic         out_ready;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [127:0] st_in  [3];
    logic [127:0] st_out [3];
    logic [127:0] got    [3];

    int checks = 0;
    int errors = 0;
    int beats_k [3] = '{4, 2, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .state_in(st_in[0]), .inv_mode(inv_mode), .out_valid(out_valid[0]),
        .out_ready(out_ready), .state_out(st_out[0]));
    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .state_in(st_in[1]), .inv_mode(inv_mode), .out_valid(out_valid[1]),
        .out_ready(out_ready), .state_out(st_out[1]));
    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .state_in(st_in[2]), .inv_mode(inv_mode), .out_valid(out_valid[2]),
        .out_ready(out_ready), .state_out(st_out[2]));

    task automatic chk(input string tag, input int k, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Column 'slot' holds w, the other three hold fill.
    function automatic logic [127:0] slot_state(input logic [31:0] w, input int s, input logic [31:0] fill);
        logic [127:0] r;
        r = {4{fill}};
        r[s*32 +: 32] = w;
        return r;
    endfunction

    // One transaction on all three engines: accept, watch latency and
    // in_ready while busy, capture result into got[], optionally drain.
    task automatic txn(input logic inv, input bit tog, input bit drain);
        int  lat [3];
        bit  seen [3];
        @(negedge clk);
        in_valid  = 1'b1;
        inv_mode  = inv;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) chk("accept_ready", k, 128'(in_ready[k]), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) st_in[k] = ~st_in[k];
        if (tog) inv_mode = ~inv_mode;
        for (int k = 0; k < 3; k++) begin
            lat[k]  = 0;
            seen[k] = 1'b0;
            chk("busy_valid", k, 128'(out_valid[k]), 128'd0);
            chk("busy_ready", k, 128'(in_ready[k]), 128'd0);
        end
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (!seen[k]) begin
                    if (out_valid[k] === 1'b1) begin
                        seen[k] = 1'b1;
                        lat[k]  = c;
                    end else begin
                        chk("busy_ready", k, 128'(in_ready[k]), 128'd0);
                    end
                end
            end
            if (tog) inv_mode = ~inv_mode;
        end
        for (int k = 0; k < 3; k++) begin
            chk("latency", k, 128'(lat[k]), 128'(beats_k[k]));
            got[k] = st_out[k];
        end
        if (drain) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                chk("drain_valid", k, 128'(out_valid[k]), 128'd0);
                chk("drain_ready", k, 128'(in_ready[k]), 128'd1);
            end
        end
    endtask

    logic [31:0]  fv_in  [4] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};
    logic [31:0]  fv_out [4] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};
    logic [127:0] exp_s;
    logic [127:0] orig [3];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        inv_mode  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) st_in[k] = '0;
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 128'(out_valid[k]), 128'd0);
            chk("rst_ready", k, 128'(in_ready[k]), 128'd1);
            chk("rst_state", k, st_out[k], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Forward and inverse known vectors in every column slot.
        for (int v = 0; v < 4; v++) begin
            for (int s = 0; s < 4; s++) begin
                for (int k = 0; k < 3; k++) st_in[k] = slot_state(fv_in[v], s, 32'h01010101);
                txn(1'b0, 1'b0, 1'b1);
                exp_s = slot_state(fv_out[v], s, 32'h01010101);
                for (int k = 0; k < 3; k++) chk("fwd_vec", k, got[k], exp_s);
                for (int k = 0; k < 3; k++) st_in[k] = slot_state(fv_out[v], s, 32'h01010101);
                txn(1'b1, 1'b0, 1'b1);
                exp_s = slot_state(fv_in[v], s, 32'h01010101);
                for (int k = 0; k < 3; k++) chk("inv_vec", k, got[k], exp_s);
            end
        end

        // Mode sampled at accept; inv_mode toggles during BUSY.
        for (int k = 0; k < 3; k++) st_in[k] = {4{32'hdb135345}};
        txn(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) chk("mode_fwd", k, got[k], {4{32'h8e4da1bc}});
        for (int k = 0; k < 3; k++) st_in[k] = {4{32'h8e4da1bc}};
        txn(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) chk("mode_inv", k, got[k], {4{32'hdb135345}});

        // Backpressure: hold 10 cycles with a new in_valid pending, then drain+load.
        for (int k = 0; k < 3; k++) st_in[k] = {4{32'hdb135345}};
        txn(1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        inv_mode = 1'b0;
        for (int k = 0; k < 3; k++) st_in[k] = {4{32'hf20a225c}};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                chk("bp_valid", k, 128'(out_valid[k]), 128'd1);
                chk("bp_state", k, st_out[k], {4{32'h8e4da1bc}});
                chk("bp_ready", k, 128'(in_ready[k]), 128'd0);
            end
        end
        for (int k = 0; k < 3; k++) st_in[k] = {4{32'hd4d4d4d5}};
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reload_valid", k, 128'(out_valid[k]), 128'd0);
            chk("reload_ready", k, 128'(in_ready[k]), 128'd0);
        end
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reload_done", k, 128'(out_valid[k]), 128'd1);
            chk("reload_state", k, st_out[k], {4{32'hd5d5d7d6}});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset one beat after accept discards the state.
        for (int k = 0; k < 3; k++) st_in[k] = {4{32'hdb135345}};
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_valid", k, 128'(out_valid[k]), 128'd0);
            chk("mid_rst_state", k, st_out[k], 128'd0);
            chk("mid_rst_ready", k, 128'(in_ready[k]), 128'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) chk("post_rst_valid", k, 128'(out_valid[k]), 128'd0);
        end

        // Random round trip: forward then inverse returns the original.
        for (int t = 0; t < 1000; t++) begin
            for (int k = 0; k < 3; k++) begin
                orig[k]  = {$urandom, $urandom, $urandom, $urandom};
                st_in[k] = orig[k];
            end
            txn(1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) st_in[k] = got[k];
            txn(1'b1, 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) chk("round_trip", k, got[k], orig[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
